stream_packer: RTL and testbench

- Downstream width-upsizing stage placed after the 32-bit valid/ready pipeline register.
- Collects PACK_RATIO consecutive input words into one wide output beat, with a per-word keep mask.
- Closes a beat early on in_last, so a packet tail leaves as a partial beat.
- Feeds the wide datapath (DMA/memory write side) using the same valid/ready handshake semantics.

---
 rtl/stream_packer_pkg.sv | 23 ++
 rtl/stream_packer_pipeline_register.sv | 31 +++
 rtl/stream_packer.sv | 98 +++++++++
 tb/tb_stream_packer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_packer_pkg.sv
// Shared sizing helpers for the stream packer and its output stage.
// All widths depend on instance parameters, so the helpers are functions, not fixed types.
package stream_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_PACK_RATIO = 4;
    localparam int MAX_PACK_RATIO     = 16;

    // Lane counter width; a ratio of 1 still needs a 1-bit counter.
    function automatic int count_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic int beat_width(input int data_width, input int ratio);
        return data_width * ratio;
    endfunction

    // Width of the held output word {last, keep, data}.
    function automatic int packed_beat_width(input int data_width, input int ratio);
        return beat_width(data_width, ratio) + ratio + 1;
    endfunction

endpackage

// File: rtl/stream_packer_pipeline_register.sv
// Single-entry valid/ready register stage; a beat is held stable until the downstream accepts it.
// Accepts a new word whenever it is empty or being emptied in the same cycle.
module pipeline_register #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_packer.sv
// Width upsizer: gathers PACK_RATIO narrow words into one wide beat with a per-lane keep mask,
// closing the beat early on in_last. The wide beat is held in a pipeline_register.
module stream_packer
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int PACK_RATIO = DEFAULT_PACK_RATIO
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic                             in_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
    output logic [PACK_RATIO-1:0]            out_keep,
    output logic                             out_last
);

    localparam int CW = count_width(PACK_RATIO);
    localparam int BW = beat_width(DATA_WIDTH, PACK_RATIO);

    typedef struct packed {
        logic                  last;
        logic [PACK_RATIO-1:0] keep;
        logic [BW-1:0]         data;
    } beat_t;

    logic [CW-1:0]         count;
    logic [BW-1:0]         asm_data;
    logic [PACK_RATIO-1:0] asm_keep;
    logic [BW-1:0]         merged_data;
    logic [PACK_RATIO-1:0] merged_keep;
    logic                  accept;
    logic                  complete;
    beat_t                 load_beat;
    beat_t                 held_beat;

    assign accept   = in_valid && in_ready;
    assign complete = (count == CW'(PACK_RATIO - 1)) || in_last;

    // Constant lane indices keep every part-select in range for any legal ratio.
    always_comb begin
        merged_data = asm_data;
        merged_keep = asm_keep;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (count == CW'(k)) begin
                merged_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
                merged_keep[k]                          = 1'b1;
            end
        end
    end

    // NOTE: the assembly buffer is reset as well, so unused upper lanes of a partial beat read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            asm_data <= '0;
            asm_keep <= '0;
        end else if (accept) begin
            if (complete) begin
                count    <= '0;
                asm_data <= '0;
                asm_keep <= '0;
            end else begin
                count    <= count + CW'(1);
                asm_data <= merged_data;
                asm_keep <= merged_keep;
            end
        end
    end

    always_comb begin
        load_beat.last = in_last;
        load_beat.keep = merged_keep;
        load_beat.data = merged_data;
    end

    pipeline_register #(
        .DATA_WIDTH ($bits(beat_t))
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && complete),
        .in_ready  (in_ready),
        .in_data   (load_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (held_beat)
    );

    assign out_data = held_beat.data;
    assign out_keep = held_beat.keep;
    assign out_last = held_beat.last;

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench for stream_packer: a 4:1 instance under directed and random traffic,
// plus a 1:1 instance that must behave as a plain registered stage.
`timescale 1ns/1ps
module tb_stream_packer;

    localparam int DW = 32;
    localparam int PR = 4;
    localparam int BW = DW * PR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_last;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready, out_last;
    logic [BW-1:0] out_data;
    logic [PR-1:0] out_keep;

    logic          in1_valid, in1_ready, in1_last;
    logic [DW-1:0] in1_data;
    logic          out1_valid, out1_ready, out1_last;
    logic [DW-1:0] out1_data;
    logic [0:0]    out1_keep;

    stream_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last)
    );

    stream_packer #(.DATA_WIDTH(DW), .PACK_RATIO(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data), .in_last(in1_last),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
        .out_keep(out1_keep), .out_last(out1_last)
    );

    typedef struct {
        logic [BW-1:0] data;
        logic [PR-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    int            tests = 0;
    int            fails = 0;
    beat_t         exp_q[$];
    logic [DW-1:0] pend_q[$];
    word_t         exp1_q[$];

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: words of the current beat accumulate in a list; a beat is emitted
    // once the list holds PR words or the word carries last. Word i goes to lane i.
    function automatic void model_accept(input logic [DW-1:0] d, input logic l);
        beat_t b;
        pend_q.push_back(d);
        if (pend_q.size() == PR || l) begin
            b.data = '0;
            b.keep = '0;
            b.last = l;
            foreach (pend_q[i]) begin
                b.data[i*DW +: DW] = pend_q[i];
                b.keep[i]          = 1'b1;
            end
            exp_q.push_back(b);
            pend_q.delete();
        end
    endfunction

    // Monitors sample on the falling edge; the bench drives inputs 1 ns after the rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_beat: got data %h keep %b with no beat expected", out_data, out_keep);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_data", out_data, b.data);
                check("beat_keep", BW'(out_keep), BW'(b.keep));
                check("beat_last", BW'(out_last), BW'(b.last));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out1_valid && out1_ready) begin
            if (exp1_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_word_r1: got data %h with no word expected", out1_data);
            end else begin
                word_t w;
                w = exp1_q.pop_front();
                check("r1_data", BW'(out1_data), BW'(w.data));
                check("r1_keep", BW'(out1_keep), BW'(1));
                check("r1_last", BW'(out1_last), BW'(w.last));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents one word and holds it until accepted; returns the number of stalled cycles.
    task automatic send_word(input logic [DW-1:0] d, input logic l, output int stalls);
        stalls    = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        @(negedge clk);
        while (!in_ready && stalls < 200) begin
            @(negedge clk);
            stalls++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready 0 for %0d cycles expected acceptance", stalls);
        end else begin
            model_accept(d, l);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send1(input logic [DW-1:0] d, input logic l);
        int waited;
        waited    = 0;
        in1_valid = 1'b1;
        in1_data  = d;
        in1_last  = l;
        @(negedge clk);
        while (!in1_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in1_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout_r1: got in_ready 0 expected acceptance");
        end else begin
            exp1_q.push_back('{data: d, last: l});
        end
        @(posedge clk);
        #1;
        in1_valid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out_valid"}, BW'(out_valid), '0);
        check({tag, "_out_data"},  out_data,       '0);
        check({tag, "_out_keep"},  BW'(out_keep),  '0);
        check({tag, "_out_last"},  BW'(out_last),  '0);
        check({tag, "_in_ready"},  BW'(in_ready),  BW'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int total_stalls;
        logic [DW-1:0] w;

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0; out1_ready = 1'b1;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2);
        check_idle_outputs("idle");

        // Full beat.
        send_word(32'h11, 1'b0, st);
        send_word(32'h22, 1'b0, st);
        send_word(32'h33, 1'b0, st);
        send_word(32'h44, 1'b0, st);
        check("full_valid", BW'(out_valid), BW'(1));
        check("full_data", out_data, 128'h00000044_00000033_00000022_00000011);
        check("full_keep", BW'(out_keep), BW'(4'b1111));
        check("full_last", BW'(out_last), '0);
        tick(1);

        // Partial tail, then a single-word packet that must start in lane 0.
        send_word(32'hA, 1'b0, st);
        send_word(32'hB, 1'b1, st);
        check("tail_data", out_data, 128'h00000000_00000000_0000000B_0000000A);
        check("tail_keep", BW'(out_keep), BW'(4'b0011));
        check("tail_last", BW'(out_last), BW'(1));
        send_word(32'hC, 1'b1, st);
        check("single_data", out_data, 128'h0000000C);
        check("single_keep", BW'(out_keep), BW'(4'b0001));
        check("single_last", BW'(out_last), BW'(1));
        tick(2);

        // Backpressure: a held beat blocks input and stays stable.
        out_ready = 1'b0;
        for (int i = 0; i < PR; i++) send_word($urandom(), 1'b0, st);
        fork
            send_word($urandom(), 1'b0, st);
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("bp_in_ready", BW'(in_ready), '0);
                    check("bp_out_valid", BW'(out_valid), BW'(1));
                    if (exp_q.size() > 0) begin
                        check("bp_hold_data", out_data, exp_q[0].data);
                        check("bp_hold_keep", BW'(out_keep), BW'(exp_q[0].keep));
                        check("bp_hold_last", BW'(out_last), BW'(exp_q[0].last));
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        for (int i = 1; i < PR; i++) send_word($urandom(), 1'b0, st);
        tick(2);

        // Reset two words into a beat: partial assembly is dropped.
        send_word(32'hDEAD0001, 1'b0, st);
        send_word(32'hDEAD0002, 1'b0, st);
        #2;
        rst = 1'b1;
        pend_q.delete();
        #1;
        check("midrst_out_valid", BW'(out_valid), '0);
        tick(1);
        rst = 1'b0;
        tick(3);
        check_idle_outputs("post_rst");
        for (int i = 0; i < PR; i++) send_word(32'hB0 + i, 1'b0, st);
        tick(2);

        // 64 random words with random gaps: 16 full beats.
        for (int i = 0; i < 64; i++) begin
            send_word($urandom(), 1'b0, st);
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        end
        tick(2);
        check("stream_drained", BW'(exp_q.size()), '0);

        // Continuous valid with out_ready high must never stall.
        total_stalls = 0;
        for (int i = 0; i < 32; i++) begin
            send_word($urandom(), 1'b0, st);
            total_stalls += st;
        end
        check("no_bubbles", BW'(total_stalls), '0);
        tick(2);

        // Random packet lengths under random backpressure.
        fork
            for (int i = 0; i < 40; i++) begin
                w = $urandom();
                send_word(w, ($urandom_range(0, 4) == 0), st);
            end
            begin
                repeat (200) begin
                    @(posedge clk);
                    #1;
                    out_ready = $urandom_range(0, 1);
                end
                out_ready = 1'b1;
            end
        join
        send_word(32'hF1F1F1F1, 1'b1, st);
        tick(3);

        // Ratio-1 build: output stream equals input stream.
        for (int i = 0; i < 20; i++) send1($urandom(), ($urandom_range(0, 2) == 0));
        tick(3);

        check("final_beats_drained", BW'(exp_q.size()), '0);
        check("final_pending_empty", BW'(pend_q.size()), '0);
        check("final_r1_drained", BW'(exp1_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
